// File: rtl/alu_seq_if.sv
// Operand/opcode request and result/flag response bundle between the decode stage,
// alu_seq and the register-file writeback.
interface alu_seq_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   s;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [W-1:0] out_hi;
  logic         z;
  logic         n;
  logic         c;
  logic         v;
  logic         err;

  modport master (
    output in_valid, a, b, s, out_ready,
    input  in_ready, out_valid, out, out_hi, z, n, c, v, err
  );

  modport slave (
    input  in_valid, a, b, s, out_ready,
    output in_ready, out_valid, out, out_hi, z, n, c, v, err
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a persistent z/n/c/v flag register.
// Define ALU_MUL_EN to build the W-cycle shift-add multiplier behind opcode 1011.
module alu_seq #(
  parameter int W = 8
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_ADC = 4'b1000;
  localparam logic [3:0] OP_SBC = 4'b1001;
  localparam logic [3:0] OP_ASR = 4'b1010;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam int         CW     = $clog2(W);

  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, MULT = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         err;
  } alu_res_t;

  function automatic alu_res_t alu_eval(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                        input logic [3:0] op, input logic cin);
    alu_res_t   r;
    logic [W:0] ext;
    r   = '0;
    ext = '0;
    case (op)
      OP_ADD, OP_ADC: begin
        ext   = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, (op == OP_ADC) & cin};
        r.res = ext[W-1:0];
        r.c   = ext[W];
        r.v   = (op_a[W-1] == op_b[W-1]) && (ext[W-1] != op_a[W-1]);
      end
      // Bit W of the extended difference is the borrow, including the borrow-in.
      OP_SUB, OP_SBC: begin
        ext   = {1'b0, op_a} - {1'b0, op_b} - {{W{1'b0}}, (op == OP_SBC) & cin};
        r.res = ext[W-1:0];
        r.c   = ext[W];
        r.v   = (op_a[W-1] != op_b[W-1]) && (ext[W-1] != op_a[W-1]);
      end
      OP_AND: r.res = op_a & op_b;
      OP_OR:  r.res = op_a | op_b;
      OP_NOT: r.res = ~op_a;
      OP_XOR: r.res = op_a ^ op_b;
      OP_SHL: begin
        r.res = {op_a[W-2:0], 1'b0};
        r.c   = op_a[W-1];
        r.v   = op_a[W-1] ^ op_a[W-2];
      end
      OP_SHR: begin
        r.res = {1'b0, op_a[W-1:1]};
        r.c   = op_a[0];
      end
      OP_ASR: begin
        r.res = {op_a[W-1], op_a[W-1:1]};
        r.c   = op_a[0];
      end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  state_t       state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic         z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;
  logic         accept;
  logic         start_mul;
  alu_res_t     alu_r;

`ifdef ALU_MUL_EN
  logic [W-1:0]  out_hi_q, out_hi_d;
  logic [W-1:0]  mcand_q, mcand_d, lo_q, lo_d, hi_q, hi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    step_sum;
  logic [W-1:0]  step_hi, step_lo;

  assign start_mul = (bus.s == OP_MUL);
  // One shift-add step: {hi,lo} holds partial product above the unconsumed multiplier bits.
  assign step_sum  = {1'b0, hi_q} + {1'b0, mcand_q & {W{lo_q[0]}}};
  assign step_hi   = step_sum[W:1];
  assign step_lo   = {step_sum[0], lo_q[W-1:1]};
`else
  assign start_mul = 1'b0;
`endif

  assign bus.in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign alu_r        = alu_eval(bus.a, bus.b, bus.s, c_q);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    err_d   = err_q;
`ifdef ALU_MUL_EN
    out_hi_d = out_hi_q;
    mcand_d  = mcand_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept && !start_mul) begin
          state_d = DONE;
          out_d   = alu_r.res;
          z_d     = (alu_r.res == '0);
          n_d     = alu_r.res[W-1];
          c_d     = alu_r.c;
          v_d     = alu_r.v;
          err_d   = alu_r.err;
`ifdef ALU_MUL_EN
          out_hi_d = '0;
`endif
        end
`ifdef ALU_MUL_EN
        else if (accept) begin
          state_d = MULT;
          mcand_d = bus.a;
          lo_d    = bus.b;
          hi_d    = '0;
          cnt_d   = '0;
        end
`endif
        else if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef ALU_MUL_EN
      MULT: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d  = DONE;
          out_d    = step_lo;
          out_hi_d = step_hi;
          z_d      = ({step_hi, step_lo} == '0);
          n_d      = step_hi[W-1];
          c_d      = (step_hi != '0);
          v_d      = 1'b0;
          err_d    = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_MUL_EN
      out_hi_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      err_q   <= err_d;
`ifdef ALU_MUL_EN
      out_hi_q <= out_hi_d;
`endif
    end
  end

`ifdef ALU_MUL_EN
  // Multiplier working registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    mcand_q <= mcand_d;
    lo_q    <= lo_d;
    hi_q    <= hi_d;
    cnt_q   <= cnt_d;
  end

  assign bus.out_hi = out_hi_q;
`else
  assign bus.out_hi = '0;
`endif

  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model with a result queue.
module tb_alu_seq;
  localparam int W = 8;
  localparam int M = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int     out;
    int     hi;
    int     z;
    int     n;
    int     c;
    int     v;
    int     err;
    longint ready;
  } exp_t;

  exp_t   q[$];
  int     mc  = 0;
  longint cyc = 0;

  function automatic int sgn(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  function automatic int ovf(input int sr);
    return ((sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)))) ? 1 : 0;
  endfunction

  function automatic exp_t model(input int a, input int b, input int s, input int cin);
    exp_t e;
    int   r;
    e.hi = 0; e.c = 0; e.v = 0; e.err = 0; e.ready = 0;
    r = 0;
    case (s)
      0:  begin r = a + b;       e.c = (r > M) ? 1 : 0; e.v = ovf(sgn(a) + sgn(b)); end
      1:  begin r = a - b;       e.c = (a < b) ? 1 : 0; e.v = ovf(sgn(a) - sgn(b)); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = ~a;
      5:  r = a ^ b;
      6:  begin r = a * 2; e.c = (a >> (W - 1)) & 1; e.v = ((a >> (W - 1)) ^ (a >> (W - 2))) & 1; end
      7:  begin r = a / 2; e.c = a % 2; end
      8:  begin r = a + b + cin; e.c = (r > M) ? 1 : 0; e.v = ovf(sgn(a) + sgn(b) + cin); end
      9:  begin r = a - b - cin; e.c = (a < b + cin) ? 1 : 0; e.v = ovf(sgn(a) - sgn(b) - cin); end
      10: begin r = (a / 2) + (a & (1 << (W - 1))); e.c = a % 2; end
      default: e.err = 1;
    endcase
    e.out = r & M;
    e.z   = (e.out == 0) ? 1 : 0;
    e.n   = (e.out >> (W - 1)) & 1;
`ifdef ALU_MUL_EN
    if (s == 11) begin
      e.err = 0;
      e.out = (a * b) & M;
      e.hi  = (a * b) >> W;
      e.c   = (e.hi != 0) ? 1 : 0;
      e.v   = 0;
      e.z   = (a * b == 0) ? 1 : 0;
      e.n   = (e.hi >> (W - 1)) & 1;
    end
`endif
    return e;
  endfunction

  // Cycle-level monitor: checks handshake and result every cycle against the model.
  always @(negedge clk) begin
    bit   ev;
    bit   eir;
    bit   is_mul;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      mc = 0;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out", bus.out, 0);
      chk("rst_out_hi", bus.out_hi, 0);
      chk("rst_flags", {bus.z, bus.n, bus.c, bus.v, bus.err}, 0);
    end else begin
      ev  = (q.size() > 0) && (cyc >= q[0].ready);
      eir = (q.size() == 0) || (ev && bus.out_ready);
      chk("mon_out_valid", bus.out_valid, ev);
      chk("mon_in_ready", bus.in_ready, eir);
      if (ev) begin
        chk("mon_out", bus.out, q[0].out);
        chk("mon_out_hi", bus.out_hi, q[0].hi);
        chk("mon_z", bus.z, q[0].z);
        chk("mon_n", bus.n, q[0].n);
        chk("mon_c", bus.c, q[0].c);
        chk("mon_v", bus.v, q[0].v);
        chk("mon_err", bus.err, q[0].err);
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && eir) begin
`ifdef ALU_MUL_EN
        is_mul = (bus.s == 4'b1011);
`else
        is_mul = 1'b0;
`endif
        e       = model(int'(bus.a), int'(bus.b), int'(bus.s), mc);
        e.ready = cyc + (is_mul ? W + 1 : 1);
        mc      = e.c;
        q.push_back(e);
      end
    end
  end

  logic [W-1:0] r_out, r_hi;
  logic         r_z, r_n, r_c, r_v, r_err;
  int           r_lat;

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
    bit acc = 1'b0;
    @(posedge clk); #1;
    bus.a = a; bus.b = b; bus.s = s;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("accept_seen", acc, 1);
    r_lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r_lat++;
      if (bus.out_valid) break;
    end
    r_out = bus.out; r_hi = bus.out_hi;
    r_z = bus.z; r_n = bus.n; r_c = bus.c; r_v = bus.v; r_err = bus.err;
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'h7F;
      2:       return 8'h80;
      3:       return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.s = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out", bus.out, 0);
    chk("reset_flags", {bus.z, bus.n, bus.c, bus.v, bus.err}, 0);
    rst_n = 1'b1;

    issue(8'h7F, 8'h01, 4'b0000);
    chk("add_ovf_out", r_out, 8'h80);
    chk("add_ovf_nvcz", {r_n, r_v, r_c, r_z}, 4'b1100);
    chk("add_ovf_err", r_err, 0);
    chk("add_latency", r_lat, 1);

    issue(8'h00, 8'h01, 4'b0001);
    chk("sub_borrow_out", r_out, 8'hFF);
    chk("sub_borrow_cnv", {r_c, r_n, r_v}, 3'b110);

    issue(8'hFF, 8'h01, 4'b0000);
    chk("add_wrap_out", r_out, 8'h00);
    chk("add_wrap_zc", {r_z, r_c}, 2'b11);
    issue(8'h10, 8'h20, 4'b1000);
    chk("adc_cin_out", r_out, 8'h31);
    chk("adc_cin_c", r_c, 0);

    issue(8'h55, 8'hAA, 4'b1100);
    chk("illegal_err", r_err, 1);
    chk("illegal_out", r_out, 8'h00);
    chk("illegal_z", r_z, 1);

    issue(8'h10, 8'h10, 4'b1011);
`ifdef ALU_MUL_EN
    chk("mul_out", r_out, 8'h00);
    chk("mul_out_hi", r_hi, 8'h01);
    chk("mul_cz", {r_c, r_z}, 2'b10);
    chk("mul_latency", r_lat, W + 1);
`else
    chk("mul_off_err", r_err, 1);
    chk("mul_off_out_hi", r_hi, 8'h00);
    chk("mul_off_latency", r_lat, 1);
`endif

    // Back-to-back ADDs with the consumer always ready.
    @(posedge clk); #1;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      bus.a = W'(i * 3 + 1);
      bus.b = W'(i + 5);
      @(negedge clk);
      chk("b2b_in_ready", bus.in_ready, 1);
      if (i > 0) chk("b2b_out_valid", bus.out_valid, 1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    bus.a = 8'h33;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_held", bus.out, 8'h12);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("async_rst_out", bus.out, 0);
    chk("async_rst_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(8'h10, 8'h20, 4'b1000);
    chk("adc_after_rst", r_out, 8'h30);

`ifdef ALU_MUL_EN
    issue(8'h7F, 8'h01, 4'b0000);
    @(posedge clk); #1;
    bus.a = 8'h10; bus.b = 8'h10; bus.s = 4'b1011;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mulrst_accept", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mulrst_busy", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mulrst_out", bus.out, 0);
    chk("mulrst_out_hi", bus.out_hi, 0);
    chk("mulrst_flags", {bus.z, bus.n, bus.c, bus.v, bus.err}, 0);
    chk("mulrst_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mulrst_ready_after", bus.in_ready, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.a = pick_val();
      bus.b = pick_val();
      bus.s = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(8, 9)) : 4'($urandom_range(0, 15));
    end

    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    chk("drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
